// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: program/run/inspect sequencer for the CPU core.
//
// Lifecycle: stream a program into instruction memory (IDLE), pulse a
// pipeline flush (FLUSH), let the core run until hlt or timeout (RUN), then
// dump all 32 registers (DREG) and the low data-memory words (DMEM) over a
// valid/ready stream, and finish in DONE.
//
// Optional build macro: DUMP_MEM_EN
//   defined   -> DMEM phase dumps data-memory words 0..DUMP_WORDS-1
//   undefined -> DREG goes straight to DONE; addr_sel_test/mem_addr_test tie 0
//
// Handshake rule for both streams (load_* and dump_*): a transfer happens on
// a rising edge where valid and ready are both 1. A producer holding valid
// keeps its data stable until that edge; ready without valid is ignored.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   load_valid/data/last/ready    program word stream into the controller
//   start                         run request (level)
//   inst_wr/addr/data             instruction memory write port
//   cpu_hlt, cpu_run, cpu_flush   core halt status, run enable, flush pulse
//   reg_sel_test/reg_index_test   register-file read override, reg_rd_data back
//   addr_sel_test/mem_addr_test   data-memory address override, mem_rd_data back
//   dump_valid/ready/data/is_mem/index   result stream
//   cycle_count, timeout, done    run statistics and completion flag
//   state                         FSM state: IDLE=0 FLUSH=1 RUN=2 DREG=3 DMEM=4 DONE=5
module cpu_run_ctrl #(
  parameter int MAX_PROG    = 1024,
  parameter int RUN_TIMEOUT = 4096,
  parameter int DUMP_WORDS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [63:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        start,
  output logic        inst_wr,
  output logic [63:0] inst_addr,
  output logic [63:0] inst_data,
  input  logic        cpu_hlt,
  output logic        cpu_run,
  output logic        cpu_flush,
  output logic        reg_sel_test,
  output logic [4:0]  reg_index_test,
  input  logic [63:0] reg_rd_data,
  output logic        addr_sel_test,
  output logic [63:0] mem_addr_test,
  input  logic [63:0] mem_rd_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [63:0] dump_data,
  output logic        dump_is_mem,
  output logic [9:0]  dump_index,
  output logic [31:0] cycle_count,
  output logic        timeout,
  output logic        done,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_RUN   = 3'd2,
    S_DREG  = 3'd3,
    S_DMEM  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(MAX_PROG + 1);

  state_t           st;
  logic [CNT_W-1:0] load_cnt;
  logic             present;   // 0 = SETUP (index driven), 1 = PRESENT (entry offered)
  logic [9:0]       idx;
  logic             beat;

  // load_ready is held low while rst is high so every output reads 0 in reset.
  assign load_ready = (st == S_IDLE) && (load_cnt < CNT_W'(MAX_PROG)) && !rst;
  assign beat       = load_valid && load_ready;
  assign inst_wr    = beat;
  assign inst_addr  = beat ? 64'(load_cnt) : 64'd0;
  assign inst_data  = beat ? load_data : 64'd0;

  assign cpu_run        = (st == S_RUN);
  assign cpu_flush      = (st == S_FLUSH);
  assign reg_sel_test   = (st == S_DREG);
  assign reg_index_test = (st == S_DREG) ? idx[4:0] : 5'd0;
  assign done           = (st == S_DONE);
  assign state          = st;

`ifdef DUMP_MEM_EN
  assign addr_sel_test = (st == S_DMEM);
  assign mem_addr_test = (st == S_DMEM) ? 64'(idx) : 64'd0;
  logic unused_in;
  assign unused_in = load_last;
`else
  assign addr_sel_test = 1'b0;
  assign mem_addr_test = 64'd0;
  logic unused_in;
  assign unused_in = load_last ^ (^mem_rd_data) ^ (DUMP_WORDS != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IDLE;
      load_cnt    <= '0;
      present     <= 1'b0;
      idx         <= 10'd0;
      dump_valid  <= 1'b0;
      dump_data   <= 64'd0;
      dump_is_mem <= 1'b0;
      dump_index  <= 10'd0;
      cycle_count <= 32'd0;
      timeout     <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          // A load beat takes priority over start in the same cycle.
          if (beat) begin
            load_cnt <= load_cnt + 1'b1;
          end else if (start && (load_cnt != '0)) begin
            st <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          cycle_count <= 32'd0;
          timeout     <= 1'b0;
          present     <= 1'b0;
          idx         <= 10'd0;
          st          <= S_RUN;
        end

        S_RUN: begin
          if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
          // hlt wins over a simultaneous timeout; the hlt cycle is counted.
          if (cpu_hlt) begin
            st <= S_DREG;
          end else if (cycle_count == 32'(RUN_TIMEOUT - 1)) begin
            timeout <= 1'b1;
            st      <= S_DREG;
          end
        end

        S_DREG: begin
          if (!present) begin
            dump_data   <= reg_rd_data;
            dump_valid  <= 1'b1;
            dump_is_mem <= 1'b0;
            dump_index  <= idx;
            present     <= 1'b1;
          end else if (dump_ready) begin
            dump_valid <= 1'b0;
            present    <= 1'b0;
            if (idx == 10'd31) begin
              idx <= 10'd0;
`ifdef DUMP_MEM_EN
              st  <= S_DMEM;
`else
              st  <= S_DONE;
`endif
            end else begin
              idx <= idx + 10'd1;
            end
          end
        end

`ifdef DUMP_MEM_EN
        S_DMEM: begin
          if (!present) begin
            dump_data   <= mem_rd_data;
            dump_valid  <= 1'b1;
            dump_is_mem <= 1'b1;
            dump_index  <= idx;
            present     <= 1'b1;
          end else if (dump_ready) begin
            dump_valid <= 1'b0;
            present    <= 1'b0;
            if (idx == 10'(DUMP_WORDS - 1)) begin
              idx <= 10'd0;
              st  <= S_DONE;
            end else begin
              idx <= idx + 10'd1;
            end
          end
        end
`endif

        S_DONE: begin
          // start re-runs the loaded program; a new word restarts loading
          // from address 0 without being accepted itself.
          if (start) begin
            st <= S_FLUSH;
          end else if (load_valid) begin
            st       <= S_IDLE;
            load_cnt <= '0;
          end
        end

        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Sequencer that owns the CPU's program/run/inspect lifecycle, replacing ad-hoc bench driving of Inst_wr, PC/IR init and the reg/mem test muxes. It streams a program into instruction memory, flushes pipeline state, runs the core until hlt or timeout, then dumps the register file and the low data-memory words over a valid/ready stream. Sits beside the CPU top and drives its existing test-port muxes.

Parameters:
MAX_PROG, 1024, instruction memory depth in words.
RUN_TIMEOUT, 4096, maximum RUN cycles before a forced stop.
DUMP_WORDS, 32, data-memory words dumped, addresses 0..DUMP_WORDS-1.

Ports:
clk in 1 system clock, rising edge
rst in 1 synchronous active-high reset
load_valid in 1 program word offered
load_data in 64 instruction word
load_last in 1 final word of program
load_ready out 1 controller accepts word
start in 1 run request, level-sampled
inst_wr out 1 instruction memory write strobe
inst_addr out 64 instruction write address
inst_data out 64 instruction write data
cpu_hlt in 1 core halted
cpu_run out 1 enables PC/IR/PC2/PC_INC update
cpu_flush out 1 one-cycle pulse: zero PC1, PC2, PC_INC, IR
reg_sel_test out 1 register-index override select
reg_index_test out 5 register index
reg_rd_data in 64 register read data (rs1)
addr_sel_test out 1 data-memory address override select
mem_addr_test out 64 data-memory address
mem_rd_data in 64 data-memory read data
dump_valid out 1 dump entry valid
dump_ready in 1 sink accepts entry
dump_data out 64 dump value
dump_is_mem out 1 0 = register entry, 1 = memory entry
dump_index out 10 register number or memory address
cycle_count out 32 RUN cycles of last/current run
timeout out 1 last run hit RUN_TIMEOUT
done out 1 dump complete
state out 3 IDLE=0 FLUSH=1 RUN=2 DREG=3 DMEM=4 DONE=5

Behaviour:
- Reset: every output 0, state IDLE, load count 0. Reset mid-operation aborts on that edge; inst_wr and cpu_run are 0 from that edge on.
- IDLE: load_ready = (load_cnt < MAX_PROG). Beat = load_valid & load_ready. On a beat, inst_wr=1 for the same cycle, inst_addr=load_cnt, inst_data=load_data, and load_cnt increments. load_last only marks the program as loaded; the block stays in IDLE.
- IDLE start handling: start with load_cnt>0 and no beat that cycle -> FLUSH. A beat has priority over start in the same cycle. start with load_cnt==0 is ignored. A beat when load_cnt==MAX_PROG is impossible because load_ready=0.
- FLUSH: cpu_flush=1 for exactly 1 cycle, cpu_run=0. cycle_count and timeout are cleared. Next state is RUN.
- RUN: cpu_run=1 and cycle_count increments each cycle. If cpu_hlt=1, leave to DREG on the next edge; the hlt cycle is counted. If cycle_count==RUN_TIMEOUT-1 and cpu_hlt=0, set timeout=1 and leave to DREG. If both occur in the same cycle, hlt wins and timeout stays 0. cpu_run=0 in every other state. load_ready=0 outside IDLE.
- DREG: reg_sel_test=1. Each entry i=0..31 takes two phases.
  - SETUP: drive reg_index_test=i for 1 cycle; read data settles combinationally.
  - PRESENT: capture reg_rd_data into dump_data and assert dump_valid, with dump_is_mem=0 and dump_index=i. Hold dump_valid and dump_data stable until dump_ready. On the handshake, go to SETUP for i+1.
  - Minimum cost is 2 cycles per entry. After entry 31, go to DMEM.
- DMEM: same two-phase scheme with addr_sel_test=1, mem_addr_test=i, dump_is_mem=1, for i=0..DUMP_WORDS-1. Then go to DONE.
- DONE: done=1. Test selects return to 0; cycle_count and timeout hold their values.
  - start=1 -> FLUSH, re-running the same program; done clears.
  - load_valid=1 with start=0 -> IDLE with load_cnt cleared; the word is not accepted.
  - start=1 and load_valid=1 together -> start wins.
- cycle_count saturates at all-ones.
- The dump stream never drops or reorders entries. dump_ready asserted while dump_valid=0 is ignored.

Optional Feature:
DUMP_MEM_EN:
- Defined: DMEM state exists as described above.
- Undefined: DREG goes directly to DONE. addr_sel_test and mem_addr_test are tied 0. DUMP_WORDS is unused.

Test Plan:
1. Load 3 words (0x...13, 0x...33, 0x7F hlt, last on the 3rd) -> three inst_wr pulses at addresses 0,1,2 with matching data; state remains IDLE.
2. Then start; core asserts cpu_hlt in the 5th RUN cycle -> one cpu_flush pulse, cpu_run high for 5 cycles, cycle_count=5, timeout=0.
3. Program with no hlt, RUN_TIMEOUT=16 -> exit after 16 RUN cycles, timeout=1, cycle_count=16.
4. Dump with dump_ready low for 3 cycles on entry 2 -> dump_data and dump_index=2 stay stable. Totals: 32 register entries, then 32 memory entries (DUMP_MEM_EN), then done=1.
5. In IDLE, load_valid and start in the same cycle -> word written, start ignored. start with no program -> stays IDLE.
6. Assert rst during DREG -> next cycle all outputs 0 and state=IDLE. A subsequent start with no reload is ignored.
